ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader_pkg.sv | 11 +
 rtl/ram_loader.sv | 127 ++++++++++++
 tb/tb_ram_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared types for the stream-to-RAM loader
package ram_loader_pkg;

   // Loader control states: waiting for a request, moving bytes, completion pulse
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - byte stream to RAM write-port loader (optional RAM_LOADER_CHECKSUM_EN adds checksum output)
module ram_loader
   import ram_loader_pkg::*;
#(
   parameter int KB = 16,
   localparam int AW = $clog2(KB * 1024)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   input  logic          abort,
   input  logic [7:0]    sdata,
   input  logic          svalid,
   output logic          sready,
   output logic [AW-1:0] a,
   output logic [7:0]    d,
   output logic          w,
   output logic          busy,
   output logic          done
`ifdef RAM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]    checksum
`endif
);

   state_t        state;
   state_t        next_state;
   logic [AW-1:0] addr_cnt;
   logic [AW:0]   remaining;
   logic          accept;
   logic          take_start;
   logic          last_byte;

   // A request is only honoured while idle; LOAD and DONE ignore start
   assign take_start = (state == S_IDLE) && start;
   assign accept     = sready && svalid;
   assign last_byte  = (remaining == (AW + 1)'(1));
   assign busy       = (state != S_IDLE);
   assign done       = (state == S_DONE);

   // Byte acceptance is combinational so an abort blocks the byte offered alongside it
   always_comb begin
      sready = 1'b0;
      if ((state == S_LOAD) && (remaining != '0) && !abort) begin
         sready = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: zero-length loads go straight to the completion pulse
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               next_state = (len == '0) ? S_DONE : S_LOAD;
            end
         end
         S_LOAD: begin
            if (abort) begin
               next_state = S_IDLE;
            end else if (accept && last_byte) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Address and byte counters: loaded on a request, stepped on every accepted byte
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_cnt  <= '0;
         remaining <= '0;
      end else if (take_start) begin
         addr_cnt  <= base;
         remaining <= len;
      end else if (accept) begin
         addr_cnt  <= addr_cnt + 1'b1;
         remaining <= remaining - 1'b1;
      end
   end

   // RAM write port: one registered strobe per accepted byte, address/data held otherwise
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         a <= '0;
         d <= '0;
         w <= 1'b0;
      end else begin
         w <= accept;
         if (accept) begin
            a <= addr_cnt;
            d <= sdata;
         end
      end
   end

`ifdef RAM_LOADER_CHECKSUM_EN
   // Running modulo-256 sum of accepted bytes, restarted by each honoured request
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         checksum <= '0;
      end else if (take_start) begin
         checksum <= '0;
      end else if (accept) begin
         checksum <= checksum + sdata;
      end
   end
`endif

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - directed self-checking bench for ram_loader (KB=1), checksum checked when RAM_LOADER_CHECKSUM_EN is defined
module tb_ram_loader;

   localparam int AW = 10;

   logic          clock;
   logic          reset;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          abort;
   logic [7:0]    sdata;
   logic          svalid;
   logic          sready;
   logic [AW-1:0] a;
   logic [7:0]    d;
   logic          w;
   logic          busy;
   logic          done;
`ifdef RAM_LOADER_CHECKSUM_EN
   logic [7:0]    checksum;
`endif

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int wr_cnt   = 0;
   int wr_mark;

   ram_loader #(.KB(1)) dut (
      .clock  (clock),
      .reset  (reset),
      .start  (start),
      .base   (base),
      .len    (len),
      .abort  (abort),
      .sdata  (sdata),
      .svalid (svalid),
      .sready (sready),
      .a      (a),
      .d      (d),
      .w      (w),
      .busy   (busy),
      .done   (done)
`ifdef RAM_LOADER_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count write strobes away from the active edge
   always @(negedge clock) begin
      if (w) wr_cnt++;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance one clock and settle 1 time unit past the rising edge
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   logic [7:0]    t1_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
   logic [AW-1:0] t2_addr  [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
   logic          t3_pat   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      reset  = 1'b0;
      start  = 1'b0;
      base   = '0;
      len    = '0;
      abort  = 1'b0;
      sdata  = '0;
      svalid = 1'b0;
      #2;
      check("rst_a", a, 0);
      check("rst_d", d, 0);
      check("rst_w", w, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sready", sready, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("rst_checksum", checksum, 0);
`endif
      tick();
      tick();
      reset = 1'b1;

      // Base load: 0x010, four bytes back to back
      start = 1'b1;
      base  = 10'h010;
      len   = 11'd4;
      tick();
      start = 1'b0;
      check("t1_busy_load", busy, 1);
      check("t1_w_none", w, 0);
      for (int i = 0; i < 4; i++) begin
         sdata  = t1_bytes[i];
         svalid = 1'b1;
         #1;
         check("t1_sready", sready, 1);
         tick();
         check("t1_w", w, 1);
         check("t1_a", a, 32'h010 + i);
         check("t1_d", d, t1_bytes[i]);
         check("t1_done", done, (i == 3) ? 1 : 0);
      end
      svalid = 1'b0;
      check("t1_sready_done", sready, 0);
      tick();
      check("t1_w_after", w, 0);
      check("t1_done_after", done, 0);
      check("t1_busy_after", busy, 0);
      check("t1_a_hold", a, 32'h013);
      check("t1_d_hold", d, 32'h44);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("t1_checksum", checksum, 32'hAA);
`endif

      // Wrap-around: 0x3FE, four bytes
      start = 1'b1;
      base  = 10'h3FE;
      len   = 11'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sdata  = 8'h01 + 8'(i);
         svalid = 1'b1;
         tick();
         check("t2_w", w, 1);
         check("t2_a", a, t2_addr[i]);
      end
      svalid = 1'b0;
      tick();

      // Backpressure: svalid 1,0,0,1,0,1 over a three-byte load
      wr_mark = wr_cnt;
      start = 1'b1;
      base  = 10'h200;
      len   = 11'd3;
      tick();
      start = 1'b0;
      for (int j = 0; j < 6; j++) begin
         svalid = t3_pat[j];
         sdata  = 8'h50 + 8'(j);
         tick();
         check("t3_w", w, t3_pat[j]);
         if (t3_pat[j]) check("t3_d", d, 32'h50 + j);
         check("t3_done", done, (j == 5) ? 1 : 0);
      end
      check("t3_a_last", a, 32'h202);
      svalid = 1'b0;
      tick();
      check("t3_w_after", w, 0);
      check("t3_wr_count", wr_cnt - wr_mark, 3);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("t3_checksum", checksum, 32'hF8);
`endif

      // Zero length: one busy cycle with done, no writes, start in DONE ignored
      wr_mark = wr_cnt;
      start  = 1'b1;
      base   = 10'h055;
      len    = 11'd0;
      svalid = 1'b1;
      #1;
      check("t4_sready_idle", sready, 0);
      tick();
      len = 11'd5;
      #1;
      check("t4_busy", busy, 1);
      check("t4_done", done, 1);
      check("t4_sready", sready, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("t4_checksum", checksum, 0);
`endif
      tick();
      start = 1'b0;
      check("t4_busy_after", busy, 0);
      check("t4_done_after", done, 0);
      check("t4_sready_after", sready, 0);
      tick();
      check("t4_ignored_start", busy, 0);
      check("t4_wr_count", wr_cnt - wr_mark, 0);
      svalid = 1'b0;

      // Abort with the third offered byte of an eight-byte load
      wr_mark = wr_cnt;
      start = 1'b1;
      base  = 10'h100;
      len   = 11'd8;
      tick();
      start  = 1'b0;
      svalid = 1'b1;
      sdata  = 8'hA1;
      tick();
      sdata  = 8'hA2;
      tick();
      sdata  = 8'hA3;
      abort  = 1'b1;
      #1;
      check("t5_sready_abort", sready, 0);
      check("t5_prev_write", w, 1);
      check("t5_prev_a", a, 32'h101);
      tick();
      abort  = 1'b0;
      svalid = 1'b0;
      check("t5_w_blocked", w, 0);
      check("t5_busy_idle", busy, 0);
      check("t5_done_none", done, 0);
      check("t5_d_hold", d, 32'hA2);
      tick();
      check("t5_done_none2", done, 0);
      check("t5_wr_count", wr_cnt - wr_mark, 2);
      start = 1'b1;
      base  = 10'h0F0;
      len   = 11'd1;
      tick();
      start  = 1'b0;
      svalid = 1'b1;
      sdata  = 8'h77;
      tick();
      svalid = 1'b0;
      check("t5_reload_w", w, 1);
      check("t5_reload_a", a, 32'h0F0);
      check("t5_reload_d", d, 32'h77);
      check("t5_reload_done", done, 1);
      tick();

      // Reset in the middle of a five-byte load
      start = 1'b1;
      base  = 10'h300;
      len   = 11'd5;
      tick();
      start  = 1'b0;
      svalid = 1'b1;
      sdata  = 8'hC1;
      tick();
      sdata  = 8'hC2;
      tick();
      check("t6_pre_w", w, 1);
      reset = 1'b0;
      #1;
      check("t6_rst_a", a, 0);
      check("t6_rst_d", d, 0);
      check("t6_rst_w", w, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_sready", sready, 0);
`ifdef RAM_LOADER_CHECKSUM_EN
      check("t6_rst_checksum", checksum, 0);
`endif
      #2;
      reset   = 1'b1;
      wr_mark = wr_cnt;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t6_quiet_w", w, 0);
         check("t6_quiet_busy", busy, 0);
         check("t6_quiet_done", done, 0);
      end
      check("t6_wr_count", wr_cnt - wr_mark, 0);
      svalid = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
